// File: rtl/max7219_sequencer.sv
// max7219_sequencer
//
// Drives the command stream for a MAX7219 7-segment display through a 16-bit
// SPI master. After reset it sends the five-word initialisation sequence, then
// one frame of digit-register writes per update request. The block owns
// chip-select and sends exactly one word per CS-low window. It uses the SPI
// master's report_ready / report_send handshake to pace the words.
//
// Ports:
//   clk              system clock
//   res              asynchronous active-low reset
//   update           frame request (level or pulse)
//   digits           BCD digits, [3:0] = digit 0 (register 0x01)
//   spi_report_ready SPI master idle/ready
//   spi_report_send  SPI master finished shifting the current word
//   spi_cs           chip-select, active-low (registered)
//   spi_word         {4'h0, addr, data}, held while spi_cs is low
//   busy             high in every state except idle
//   init_done        init sequence has completed since reset
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (data 0x0F) in each frame. Digit 0 is never blanked.

module max7219_sequencer #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter logic [3:0]  INTENSITY  = 4'hF,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    update,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    spi_report_ready,
    input  logic                    spi_report_send,
    output logic                    spi_cs,
    output logic [15:0]             spi_word,
    output logic                    busy,
    output logic                    init_done
);

    localparam int unsigned    GapW      = (CS_GAP < 1) ? 1 : $clog2(CS_GAP + 1);
    localparam logic [GapW-1:0] GapMax   = GapW'(CS_GAP);
    localparam logic [2:0]     LastInit  = 3'd4;
    localparam logic [2:0]     LastDigit = 3'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        StInitLoad,
        StWaitRdy,
        StCsLow,
        StCsHigh,
        StIdle
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic            frame_q, frame_d;      // 0: sending init words, 1: sending a frame
    logic            pending_q, pending_d;
    logic            init_done_q, init_done_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            cs_q, cs_d;
    logic [15:0]     word_q, word_d;
    logic [31:0]     digits_q, digits_d;    // zero-padded to 8 digits

    logic        launch;
    logic        sent;
    logic        last_step;
    logic        frame_start;
    logic [15:0] init_word;
    logic [15:0] frame_word;
    logic [15:0] next_word;
    logic [3:0]  digit_nib;
    logic [7:0]  frame_data;
    logic [3:0]  digit_addr;

    // Handshake qualifiers; ready is only looked at in WAIT_RDY, so its stale
    // value during the CS-falling cycle cannot start a second word.
    assign launch      = (state_q == StWaitRdy) && spi_report_ready && (gap_q >= GapMax);
    assign sent        = (state_q == StCsLow) && spi_report_send;
    assign last_step   = frame_q ? (step_q == LastDigit) : (step_q == LastInit);
    assign frame_start = ((state_q == StIdle) || ((state_q == StCsHigh) && last_step))
                         && (pending_q || update);

    // Word selection
    always_comb begin
        unique case (step_q)
            3'd0:    init_word = 16'h0F00;
            3'd1:    init_word = 16'h09FF;
            3'd2:    init_word = {8'h0A, 4'h0, INTENSITY};
            3'd3:    init_word = {8'h0B, 5'h00, LastDigit};
            default: init_word = 16'h0C01;
        endcase
    end

    assign digit_nib  = digits_q[{step_q, 2'b00} +: 4];
    assign digit_addr = {1'b0, step_q} + 4'd1;

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] blank;
    logic       nz_above;

    // blank[k]: digit k and every digit above it are zero
    always_comb begin
        blank    = '0;
        nz_above = 1'b0;
        for (int k = 7; k >= 1; k--) begin
            nz_above = nz_above | (digits_q[4*k +: 4] != 4'h0);
            blank[k] = !nz_above;
        end
    end

    assign frame_data = blank[step_q] ? 8'h0F : {4'h0, digit_nib};
`else
    assign frame_data = {4'h0, digit_nib};
`endif

    assign frame_word = {4'h0, digit_addr, frame_data};
    assign next_word  = frame_q ? frame_word : init_word;

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= StInitLoad;
            step_q      <= 3'd0;
            frame_q     <= 1'b0;
            pending_q   <= 1'b0;
            init_done_q <= 1'b0;
            gap_q       <= '0;
            cs_q        <= 1'b1;
            word_q      <= 16'h0000;
            digits_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            frame_q     <= frame_d;
            pending_q   <= pending_d;
            init_done_q <= init_done_d;
            gap_q       <= gap_d;
            cs_q        <= cs_d;
            word_q      <= word_d;
            digits_q    <= digits_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        frame_d     = frame_q;
        init_done_d = init_done_q;
        digits_d    = digits_q;
        pending_d   = pending_q | update;
        gap_d       = (gap_q < GapMax) ? gap_q + GapW'(1) : gap_q;

        // An update seen in the frame-start cycle is served by that frame.
        if (frame_start) begin
            pending_d = 1'b0;
            digits_d  = 32'(digits);
            frame_d   = 1'b1;
            step_d    = 3'd0;
        end

        unique case (state_q)
            StInitLoad: state_d = StWaitRdy;
            StWaitRdy: begin
                if (launch) state_d = StCsLow;
            end
            StCsLow: begin
                if (sent) state_d = StCsHigh;
            end
            StCsHigh: begin
                gap_d = '0;
                if (last_step) begin
                    step_d = 3'd0;
                    if (!frame_q) init_done_d = 1'b1;
                    if (frame_start) begin
                        state_d = StWaitRdy;
                    end else begin
                        state_d = StIdle;
                        frame_d = 1'b0;
                    end
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = frame_q ? StWaitRdy : StInitLoad;
                end
            end
            StIdle: begin
                if (frame_start) state_d = StWaitRdy;
            end
            default: state_d = StInitLoad;
        endcase
    end

    // Output logic: CS and word are registered so CS never glitches
    always_comb begin
        cs_d   = cs_q;
        word_d = word_q;
        if (launch) begin
            cs_d   = 1'b0;
            word_d = next_word;
        end
        if (sent) begin
            cs_d = 1'b1;
        end
    end

    assign busy      = (state_q != StIdle);
    assign spi_cs    = cs_q;
    assign spi_word  = word_q;
    assign init_done = init_done_q;

endmodule

// File: doc/max7219_sequencer.md
# max7219_sequencer

Command sequencer feeding the 16-bit SPI master that drives the MAX7219 7-segment display of the clock. After reset it sends the fixed MAX7219 initialisation sequence. It then sends one frame of digit-register writes per `update` request, taking digits from a BCD bus. It owns chip-select and runs the `report_ready` / `report_send` handshake, so the SPI master transfers exactly one word per CS-low window.

## Interface
- `NUM_DIGITS`, 8, number of digits driven, legal 1..8
- `INTENSITY`, 4'hF, value written to the intensity register 0x0A
- `CS_GAP`, 2, minimum cycles `spi_cs` stays high between words, legal ≥1

- `clk` input 1: system clock, the only clock.
- `res` input 1: reset, asynchronous, active-low.
- `update` input 1: request a digit frame; level or pulse, sampled every cycle.
- `digits` input 4*NUM_DIGITS: BCD digits; [3:0] is digit 0 (rightmost, register 0x01).
- `spi_report_ready` input 1: SPI master idle and ready.
- `spi_report_send` input 1: SPI master has shifted out the word.
- `spi_cs` output 1: chip-select to the SPI master `cs_in` and to the MAX7219; active-low.
- `spi_word` output 16: word to transmit, {4'h0, addr[3:0], data[7:0]}.
- `busy` output 1: init or frame in progress.
- `init_done` output 1: initialisation sequence completed since last reset.

## Operation
- States:
  - INIT_LOAD: select the next init word.
  - WAIT_RDY: `spi_cs`=1; wait until `spi_report_ready`=1 and the gap counter reaches ≥CS_GAP.
  - CS_LOW: `spi_cs`=0, `spi_word` held stable; wait for `spi_report_send`=1.
  - CS_HIGH: `spi_cs`=1; gap counter cleared; advance the step index.
  - IDLE.
- Init sequence, in order: 0x0F00 (test off), 0x09FF (BCD decode all), 0x0A0{INTENSITY}, 0x0B0{NUM_DIGITS-1}, 0x0C01 (normal operation).
- After the last init word, `init_done`←1.
  - If an update is pending, go to the frame. Otherwise go to IDLE.
- Frame sequence: digit k = 0..NUM_DIGITS-1 sent as {4'h0, k+1, 4'h0, digit_k}, ascending.
- `digits` is snapshotted into an internal register when the frame starts. Changes during a frame affect only the next frame.
- Pending flag:
  - Set by `update`=1 in any state.
  - Cleared when a frame starts.
  - Requests arriving while busy coalesce into one follow-up frame.
  - An update during init is serviced immediately after init.
- Step index width is 3 bits; it wraps to 0 at frame or init end. No out-of-range address is ever emitted.
- `busy` is 1 in every state except IDLE.

## Timing
- Reset values: `spi_cs`=1, `spi_word`=16'h0000, `busy`=1, `init_done`=0, pending=0, step=0, state=INIT_LOAD.
- Asserting `res` mid-word forces `spi_cs` high asynchronously. Init restarts from word 0 after release.
- CS falls on the clock edge following the cycle where `spi_report_ready`=1 and the gap is satisfied.
- `spi_word` is valid on that same edge and is held until CS rises.
- CS rises on the edge following the first cycle with `spi_report_send`=1.
- `spi_report_ready` is ignored while CS is low. Its stale value in the CS-falling cycle must not cause a double send.
- Per word, with the 4-cycles/bit SPI master: 1 (CS fall) + 64 (shift) + ~2 (DONE/report) + CS_GAP + ready return.
- In IDLE, a frame begins the cycle after `update` is seen.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined: in each frame, digits from the MSB downward that are 0 are sent with data 0x0F (Code-B blank) until the first nonzero digit. Digit 0 is never blanked.
  - Undefined: all digits are sent verbatim; no blanking logic is synthesised.

## Test plan
- Release `res` with an SPI master model: exactly five CS-low windows with words 0x0F00, 0x09FF, 0x0A0F, 0x0B07, 0x0C01. Then `init_done`=1 and `busy`=0.
- `update` pulse, `digits`=32'h12345678: eight words 0x0108, 0x0207, …, 0x0801, each bracketed by its own CS window, with CS high ≥2 cycles between windows.
- Three `update` pulses during a frame: exactly one extra frame follows, using `digits` sampled at that frame's start.
- `res` asserted while CS is low mid-transfer: `spi_cs`=1 immediately. After release, the sequence restarts at 0x0F00.
- With LEADING_ZERO_BLANK_EN, `digits`=32'h00000450: words 0x0100, 0x0205, 0x0304, then 0x040F…0x080F.
- `spi_report_send` held low indefinitely: CS stays low, `spi_word` stays stable, and no further words are issued.
